// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h index-address memory sequencer:
// operand size codes, sequencer states and an operand byte picker.
package jt900h_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_BEAT      = 2'd2,
    ST_DONE      = 2'd3
  } idxmem_st_e;

  function automatic logic [7:0] op_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jt900h_idxmem_lane.sv
// Combinational beat planner: for a given size, start-address parity and beat
// index, gives the lane enables, byte offset from the start address and first operand byte.
module jt900h_idxmem_lane
  import jt900h_pkg::*;
(
  input  logic [1:0] size,
  input  logic       a0,
  input  logic [1:0] bidx,
  output logic [1:0] be,
  output logic [1:0] off,
  output logic [1:0] sel,
  output logic       last
);

  always_comb begin
    be   = 2'b11;
    off  = 2'd0;
    sel  = 2'd0;
    last = 1'b1;
    if (size == SZ_BYTE) begin
      be = a0 ? 2'b10 : 2'b01;
    end else if (size == SZ_WORD) begin
      if (a0 && bidx == 2'd0) begin
        be   = 2'b10;
        last = 1'b0;
      end else if (a0) begin
        be  = 2'b01;
        off = 2'd1;
        sel = 2'd1;
      end
    end else if (!a0) begin
      // long (and the reserved code) on an even address: two full words
      if (bidx == 2'd0) begin
        last = 1'b0;
      end else begin
        off = 2'd2;
        sel = 2'd2;
      end
    end else begin
      case (bidx)
        2'd0: begin
          be   = 2'b10;
          last = 1'b0;
        end
        2'd1: begin
          off  = 2'd1;
          sel  = 2'd1;
          last = 1'b0;
        end
        default: begin
          be  = 2'b01;
          off = 2'd3;
          sel = 2'd3;
        end
      endcase
    end
  end

endmodule

// File: rtl/jt900h_idxmem.sv
// Operand read/write sequencer: turns an effective byte address and operand size
// into aligned beats on the 16-bit little-endian bus and reassembles read data.
module jt900h_idxmem
  import jt900h_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic [31:0]   wdata,
  input  logic          idx_ok,
  input  logic [AW-1:0] idx_addr,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-2:0] bus_addr,
  output logic [1:0]    bus_be,
  output logic [15:0]   bus_dout,
  input  logic [15:0]   bus_din,
  input  logic          bus_ack,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          done
);

  idxmem_st_e    st_q, st_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [1:0]    lane_be, lane_off, lane_sel, hi_sel;
  logic          lane_last, in_beat;
  logic [AW-1:0] beat_addr;

  jt900h_idxmem_lane u_lane (
    .size (size_q),
    .a0   (addr_q[0]),
    .bidx (bidx_q),
    .be   (lane_be),
    .off  (lane_off),
    .sel  (lane_sel),
    .last (lane_last)
  );

  // With both lanes enabled the odd lane carries the following operand byte.
  assign hi_sel    = lane_be[0] ? lane_sel + 2'd1 : lane_sel;
  assign beat_addr = addr_q + {{(AW-2){1'b0}}, lane_off};
  assign in_beat   = (st_q == ST_BEAT);

  assign bus_req  = in_beat;
  assign bus_we   = in_beat & wr_q;
  assign bus_addr = in_beat ? beat_addr[AW-1:1] : '0;
  assign bus_be   = in_beat ? lane_be : 2'b00;
  assign bus_dout = {(bus_we && lane_be[1]) ? op_byte(wdata_q, hi_sel)   : 8'h00,
                     (bus_we && lane_be[0]) ? op_byte(wdata_q, lane_sel) : 8'h00};
  assign busy     = (st_q == ST_WAIT_ADDR) || (st_q == ST_BEAT);
  assign done     = (st_q == ST_DONE);
  assign rdata    = rdata_q;

  always_comb begin
    st_d    = st_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    bidx_d  = bidx_q;
    rdata_d = rdata_q;
    if (cen) begin
      case (st_q)
        ST_IDLE: if (start) begin
          wr_d    = wr;
          size_d  = size;
          wdata_d = wdata;
          rdata_d = '0;
          bidx_d  = 2'd0;
          if (idx_ok) begin
            addr_d = idx_addr;
            st_d   = ST_BEAT;
          end else begin
            st_d = ST_WAIT_ADDR;
          end
        end
        ST_WAIT_ADDR: if (idx_ok) begin
          addr_d = idx_addr;
          st_d   = ST_BEAT;
        end
        ST_BEAT: if (bus_ack) begin
          if (!wr_q) begin
            for (int i = 0; i < 4; i++) begin
              if (lane_be[0] && lane_sel == 2'(i)) rdata_d[8*i +: 8] = bus_din[7:0];
              if (lane_be[1] && hi_sel == 2'(i))   rdata_d[8*i +: 8] = bus_din[15:8];
            end
          end
          if (lane_last) st_d = ST_DONE;
          else           bidx_d = bidx_q + 2'd1;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      wdata_q <= '0;
      addr_q  <= '0;
      bidx_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      st_q    <= st_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      bidx_q  <= bidx_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
